// File: rtl/keypad_pkg.sv
// Shared types for the hex keypad scanner: debounce states, frame classes and
// the frame-bit to key-code mapping.
package keypad_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCand,
        StHeld,
        StRelease
    } key_state_e;

    typedef enum logic [1:0] {
        ClsNone,
        ClsSingle,
        ClsMulti
    } frame_class_e;

    // Frame bit index is {col, row}; key code is {row, col}.
    function automatic logic [KEY_W-1:0] bit_to_code(input logic [3:0] idx);
        return {idx[1:0], idx[3:2]};
    endfunction

endpackage

// File: rtl/keypad_frame_scan.sv
// Column scanner: divider, one-hot column drive, row synchronizer, 16-bit frame
// capture and per-frame classification into none / single key / multiple keys.
module keypad_frame_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [3:0]        i_Rows,
    output logic [3:0]        o_Cols,
    output logic              o_Frame_End,
    output frame_class_e      o_Frame_Class,
    output logic [KEY_W-1:0]  o_Frame_Code
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_q, col_d;
    logic [3:0]      rows_meta_q, rows_meta_d;
    logic [3:0]      rows_sync_q, rows_sync_d;
    logic [15:0]     frame_q, frame_d;
    logic            term;
    logic            seen;
    logic            multi;
    logic [3:0]      hit_idx;

    assign term = (div_q == DivW'(SCAN_DIV - 1));

    always_comb begin
        rows_meta_d = i_Rows;
        rows_sync_d = rows_meta_q;
        div_d       = term ? '0 : div_q + DivW'(1);
        col_d       = col_q;
        frame_d     = frame_q;
        if (term) begin
            frame_d[{col_q, 2'b00} +: 4] = rows_sync_q;
            col_d                        = col_q + 2'd1;
        end
    end

    // Classify the image including the column being captured this cycle, so the
    // FSM sees the complete frame on the frame-end edge.
    always_comb begin
        seen    = 1'b0;
        multi   = 1'b0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_d[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen    = 1'b1;
                hit_idx = 4'(i);
            end
        end
        if (multi) begin
            o_Frame_Class = ClsMulti;
        end else if (seen) begin
            o_Frame_Class = ClsSingle;
        end else begin
            o_Frame_Class = ClsNone;
        end
        o_Frame_Code = bit_to_code(hit_idx);
    end

    assign o_Frame_End = term && (col_q == 2'd3);
    assign o_Cols      = 4'b0001 << col_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            div_q       <= '0;
            col_q       <= 2'd0;
            rows_meta_q <= 4'd0;
            rows_sync_q <= 4'd0;
            frame_q     <= 16'd0;
        end else begin
            div_q       <= div_d;
            col_q       <= col_d;
            rows_meta_q <= rows_meta_d;
            rows_sync_q <= rows_sync_d;
            frame_q     <= frame_d;
        end
    end

endmodule

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad reader: frame scanner plus a press/release debounce FSM that
// emits one code per press and shifts it into a 16-bit entry register.
module hex_keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    output logic [3:0]        o_Cols,
    input  logic [3:0]        i_Rows,
    input  logic              i_Clear,
    output logic [KEY_W-1:0]  o_Key,
    output logic              o_Key_DV,
    output logic              o_Pressed,
    output logic [15:0]       o_Data
);

    localparam logic [3:0] DebCnt = 4'(DEBOUNCE);

    logic              frame_end;
    frame_class_e      frame_class;
    logic [KEY_W-1:0]  frame_code;

    key_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        cnt_inc;
    logic [KEY_W-1:0]  cand_q, cand_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_dv_q, key_dv_d;
    logic [15:0]       data_q, data_d;
    logic              accept;

    keypad_frame_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_frame_scan (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Rows        (i_Rows),
        .o_Cols        (o_Cols),
        .o_Frame_End   (frame_end),
        .o_Frame_Class (frame_class),
        .o_Frame_Code  (frame_code)
    );

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_class == ClsSingle) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DebCnt == 4'd1) begin
                            state_d = StHeld;
                            accept  = 1'b1;
                        end else begin
                            state_d = StCand;
                        end
                    end
                end
                StCand: begin
                    if (frame_class != ClsSingle) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else if (frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebCnt) begin
                            state_d = StHeld;
                            accept  = 1'b1;
                        end
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end
                end
                StHeld: begin
                    if (frame_class == ClsNone) begin
                        cnt_d   = 4'd1;
                        state_d = (DebCnt == 4'd1) ? StIdle : StRelease;
                    end
                end
                StRelease: begin
                    if (frame_class != ClsNone) begin
                        state_d = StHeld;
                    end else if (cnt_inc == DebCnt) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Clear takes priority over the shift, but the key strobe still fires.
    always_comb begin
        key_dv_d = accept;
        key_d    = accept ? frame_code : key_q;
        data_d   = accept ? {data_q[11:0], frame_code} : data_q;
        if (i_Clear) begin
            data_d = 16'd0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            cand_q   <= '0;
            key_q    <= '0;
            key_dv_q <= 1'b0;
            data_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            key_q    <= key_d;
            key_dv_q <= key_dv_d;
            data_q   <= data_d;
        end
    end

    assign o_Key     = key_q;
    assign o_Key_DV  = key_dv_q;
    assign o_Pressed = (state_q == StHeld) || (state_q == StRelease);
    assign o_Data    = data_q;

endmodule

// File: tb/tb_hex_keypad_scan.sv
// Directed bench for hex_keypad_scan with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames)
// and a behavioural 4x4 key matrix closing rows against the driven column.
module tb_hex_keypad_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        clear;
    logic [3:0]  key;
    logic        key_dv;
    logic        pressed;
    logic [15:0] data;

    logic [15:0] keys;  // bit r*4+c set = key (row r, col c) held
    int          checks;
    int          errors;
    int          dv_count;
    int          seq_idx [5];

    hex_keypad_scan #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .o_Cols    (cols),
        .i_Rows    (rows),
        .i_Clear   (clear),
        .o_Key     (key),
        .o_Key_DV  (key_dv),
        .o_Pressed (pressed),
        .o_Data    (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && cols[c]) begin
                    rows[r] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_dv === 1'b1) begin
            dv_count++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leave the bench just after the edge where column 0 becomes active again.
    task automatic align();
        logic found;
        logic [3:0] prev;
        found = 1'b0;
        prev  = cols;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (prev == 4'b1000 && cols == 4'b0001) begin
                found = 1'b1;
            end
            prev = cols;
        end
        check("align_frame_start", 16'(found), 16'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        dv_count = 0;
        keys     = 16'd0;
        clear    = 1'b0;
        rst      = 1'b1;
        seq_idx  = '{1, 2, 3, 4, 15};

        // Reset and column rotation
        step(3);
        check("rst_cols", 16'(cols), 16'h0001);
        check("rst_data", data, 16'h0000);
        check("rst_dv", 16'(key_dv), 16'd0);
        check("rst_key", 16'(key), 16'd0);
        check("rst_pressed", 16'(pressed), 16'd0);
        rst = 1'b0;
        step(3);
        check("cols_c0", 16'(cols), 16'h0001);
        step(1);
        check("cols_c1", 16'(cols), 16'h0002);
        step(4);
        check("cols_c2", 16'(cols), 16'h0004);
        step(4);
        check("cols_c3", 16'(cols), 16'h0008);
        step(4);
        check("cols_wrap", 16'(cols), 16'h0001);

        // Single press r2c1, held 6 frames
        align();
        keys = 16'(1) << 9;
        step(31);
        check("single_no_early_dv", 16'(key_dv), 16'd0);
        check("single_no_early_pressed", 16'(pressed), 16'd0);
        step(1);
        check("single_dv", 16'(key_dv), 16'd1);
        check("single_key", 16'(key), 16'h0009);
        check("single_data", data, 16'h0009);
        check("single_pressed", 16'(pressed), 16'd1);
        step(1);
        check("single_dv_one_cycle", 16'(key_dv), 16'd0);
        step(63);
        keys = 16'd0;
        step(31);
        check("release_still_pressed", 16'(pressed), 16'd1);
        step(1);
        check("release_pressed_fall", 16'(pressed), 16'd0);
        check("single_strobe_count", 16'(dv_count), 16'd1);

        // Sequence 1,2,3,4 then F
        for (int k = 0; k < 5; k++) begin
            keys = 16'(1) << seq_idx[k];
            step(64);
            keys = 16'd0;
            step(64);
            if (k == 3) begin
                check("seq_data_1234", data, 16'h1234);
                check("seq_strobes_4", 16'(dv_count), 16'd5);
            end
        end
        check("seq_data_234f", data, 16'h234F);
        check("seq_key_f", 16'(key), 16'h000F);
        check("seq_strobes_5", 16'(dv_count), 16'd6);

        // Bounce r1c1: on/off/on/off one frame each
        keys = 16'(1) << 5;
        step(16);
        keys = 16'd0;
        step(16);
        keys = 16'(1) << 5;
        step(16);
        keys = 16'd0;
        step(16);
        check("bounce_no_strobe", 16'(dv_count), 16'd6);
        check("bounce_idle", 16'(pressed), 16'd0);
        check("bounce_data_kept", data, 16'h234F);

        // r0c0 + r1c1 together, then r0c0 alone
        keys = 16'h0021;
        step(64);
        check("multi_no_strobe", 16'(dv_count), 16'd6);
        check("multi_not_pressed", 16'(pressed), 16'd0);
        keys = 16'h0001;
        step(48);
        check("multi_then_single_strobe", 16'(dv_count), 16'd7);
        check("multi_then_single_key", 16'(key), 16'h0000);
        check("multi_then_single_data", data, 16'h34F0);
        keys = 16'd0;
        step(32);

        // Clear coinciding with acceptance of r1c1
        keys = 16'(1) << 5;
        step(31);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_dv", 16'(key_dv), 16'd1);
        check("clear_key", 16'(key), 16'h0005);
        check("clear_data", data, 16'h0000);
        step(16);

        // Reset while held; key re-accepted after 2 frames
        rst = 1'b1;
        step(3);
        check("mid_rst_cols", 16'(cols), 16'h0001);
        check("mid_rst_key", 16'(key), 16'd0);
        check("mid_rst_dv", 16'(key_dv), 16'd0);
        check("mid_rst_pressed", 16'(pressed), 16'd0);
        check("mid_rst_data", data, 16'h0000);
        rst = 1'b0;
        step(31);
        check("post_rst_no_early_dv", 16'(key_dv), 16'd0);
        step(1);
        check("post_rst_dv", 16'(key_dv), 16'd1);
        check("post_rst_key", 16'(key), 16'h0005);
        check("post_rst_data", data, 16'h0005);
        keys = 16'd0;
        step(2);
        check("total_strobes", 16'(dv_count), 16'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scan.md
# hex_keypad_scan

Scans a 4x4 hex matrix keypad by driving one column at a time and sampling the four rows. It debounces the result and emits one 4-bit hex code per key press. Codes are shifted into a 16-bit entry register that feeds `sixteen_bit_drv.data` directly, so typed digits appear on the display. This is the input-side counterpart of the multiplexed display path: it performs the same column scanning, but reads rather than drives.

## Interface
Parameters:
- `SCAN_DIV`, default 1024: clocks per column. Must be ≥ 4.
- `DEBOUNCE`, default 4: consecutive identical frames needed to accept a press or a release. Range 1..15.

Ports:
- `i_Clk`  in  1  system clock.
- `i_Rst`  in  1  synchronous, active-high reset.
- `o_Cols`  out  4  one-hot column drive, active-high; bit n drives column n.
- `i_Rows`  in  4  raw row sense, active-high, asynchronous to `i_Clk`.
- `i_Clear`  in  1  synchronously clears `o_Data`.
- `o_Key`  out  4  code of the last accepted key.
- `o_Key_DV`  out  1  one-cycle strobe when a new key is accepted.
- `o_Pressed`  out  1  high while the FSM is in HELD or RELEASE.
- `o_Data`  out  16  entry register; newest code in `[3:0]`.

## Operation
- **Row synchronizer:** `i_Rows` passes through a 2-flop synchronizer before any use.
- **Divider:** counts 0..SCAN_DIV-1.
  - At terminal count, the synchronized rows for the current column are captured into a 16-bit frame image at bits `[col*4 + row]`.
  - The column index then advances (0→1→2→3→0), and `o_Cols` updates to match.
- **Frame end:** occurs at the capture of column 3. The frame is classified as:
  - NONE: no bits set.
  - SINGLE: exactly one bit set; its code is `row*4 + col`.
  - MULTI: two or more bits set.
- **Key-to-code map:** key at row r, column c gives code `4r + c`. Examples: r0c1 = 0x1, r1c0 = 0x4, r2c1 = 0x9, r3c3 = 0xF.
- **Debounce FSM:** states IDLE, CAND, HELD, RELEASE. It is evaluated only at frame end and holds state otherwise.
  - IDLE: on SINGLE, latch the candidate code, set count = 1, go to CAND. On NONE or MULTI, stay.
  - CAND:
    - SINGLE with the same code: count++.
    - SINGLE with a different code: reload the candidate, set count = 1.
    - NONE or MULTI: go to IDLE.
    - When count reaches DEBOUNCE: go to HELD and accept the key.
  - HELD: any non-NONE frame keeps HELD. A NONE frame sets count = 1 and goes to RELEASE.
  - RELEASE:
    - NONE: count++. When count reaches DEBOUNCE, go to IDLE.
    - Any non-NONE frame: return to HELD. No new acceptance occurs.
- **DEBOUNCE = 1:** acceptance happens on the first SINGLE frame, directly from IDLE to HELD. Release completes on the first NONE frame, directly from HELD to IDLE.
- **Accept action:**
  - `o_Key` ← code.
  - `o_Key_DV` = 1 for one cycle.
  - `o_Data` ← `{o_Data[11:0], code}`; the oldest nibble is discarded.
- **Auto-repeat:** none. A second key pressed while another is held is ignored.
- **`i_Clear`:** `o_Data` ← 0 on the next edge. If it coincides with an accept, clear wins: `o_Data` = 0, but `o_Key` and `o_Key_DV` still update.
- **Reset values:**
  - `o_Cols` = 0001, column index = 0, divider = 0.
  - FSM = IDLE, count = 0, frame image = 0.
  - `o_Key` = 0, `o_Key_DV` = 0, `o_Pressed` = 0, `o_Data` = 0.
- **Reset mid-operation:** all state is lost. A key still held after reset is accepted again after DEBOUNCE SINGLE frames.

## Timing
- One frame = 4·SCAN_DIV cycles.
- Row-sense latency is 2 cycles. Each column's sample is taken at its last divider count, so rows have settled for SCAN_DIV−1 cycles.
- `o_Key_DV` asserts on the cycle after the frame-end edge of the DEBOUNCE-th matching frame. `o_Key` and `o_Data` update on that same cycle.
- From a clean press aligned to frame start, the worst case is 1 + DEBOUNCE frames plus 3 cycles.
- `o_Pressed` rises with `o_Key_DV`. It falls the cycle after the frame-end edge of the DEBOUNCE-th NONE frame.
- `o_Cols` changes the cycle after the divider terminal count.

## Structure
- **Package `keypad_pkg`:**
  - State enum: IDLE, CAND, HELD, RELEASE.
  - `KEY_W` = 4.
  - Frame-class enum: NONE, SINGLE, MULTI.
- **Sub-module `keypad_frame_scan`:**
  - Contains the divider, column drive, row synchronizer, frame capture and classifier.
  - Outputs `frame_end`, `frame_class`, `frame_code`.
- **Top level:** holds the debounce FSM and the entry register.

## Test plan
Bench uses SCAN_DIV = 4, DEBOUNCE = 2, so one frame = 16 cycles. The keypad model closes row r when `o_Cols[c]` is driven and key (r,c) is pressed.

- **Reset:** assert `i_Rst` 3 cycles → `o_Cols` = 0001, `o_Data` = 0x0000, `o_Key_DV` = 0. Columns cycle 0001→0010→0100→1000 every 4 cycles thereafter.
- **Single press:** hold r2c1 for 6 frames, then release → exactly one `o_Key_DV` with `o_Key` = 0x9, `o_Data` = 0x0009. `o_Pressed` falls 2 NONE frames after release.
- **Sequence:** press/release r0c1, r0c2, r0c3, r1c0, each held 4 frames with 4 idle frames between → `o_Data` = 0x1234 and 4 strobes. A fifth key, r3c3, gives `o_Data` = 0x234F.
- **Bounce:** r1c1 on 1 frame, off 1 frame, on 1 frame, off → no `o_Key_DV`, FSM back in IDLE.
- **Multiple keys:** r0c0 and r1c1 together for 4 frames → no strobe. Release r1c1 and keep r0c0 for 3 frames → one strobe, `o_Key` = 0x0.
- **Clear collision and reset:**
  - `i_Clear` on the accept cycle of 0x5 → `o_Data` = 0x0000, `o_Key` = 0x5, strobe present.
  - Then `i_Rst` while HELD with r1c1 still held → all outputs reset, and `o_Key_DV` fires again with 0x5 after 2 frames.
